sha2_logic_pipe: RTL and testbench
==================================

Name: sha2_logic_pipe

Overview:
- Parametrised, pipelined SHA-2 logical-function unit. Successor to the single-function 32-bit majority register.
- Computes one of Maj, Ch, Σ0, Σ1, σ0, σ1 per transaction, selected by an op code, for SHA-256 (WORD_W=32) or SHA-512 (WORD_W=64).
- Sits between the round/message-schedule controller and the adder tree.
- Uses a two-stage elastic valid/ready pipeline with full throughput, a pass-through tag and an error flag.

Parameters:
- WORD_W, 32, word width; legal values are 32 and 64 only (elaboration error otherwise).
- TAG_W, 4, width of the opaque tag carried with each transaction.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept an input this cycle.
- in_op  in  3  0=MAJ 1=CH 2=BSIG0 3=BSIG1 4=SSIG0 5=SSIG1; 6 and 7 are illegal.
- in_a  in  WORD_W  operand x (the only operand for the sigma ops).
- in_b  in  WORD_W  operand y.
- in_c  in  WORD_W  operand z.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WORD_W  function result.
- out_tag  out  TAG_W  tag of the transaction being presented.
- out_err  out  1  presented transaction had an illegal op.
- op_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (asynchronous, active-low): all valids, out_result, out_tag, out_err and op_count go to 0 immediately. In-flight data is discarded; mid-operation reset loses transactions, with no partial output. in_ready is 1 in the first cycle after reset deasserts.
- Handshake: a transfer occurs on a clock edge where valid && ready.
  - out_valid, out_result, out_tag and out_err hold stable while out_valid && !out_ready.
  - in_ready must not depend combinationally on in_valid.
- Stage S1 registers op, a, b, c and tag on an input handshake.
- Stage S2 registers the computed result, tag and err.
  - S1 advances into S2 when S2 is empty or S2 is handshaking in the same cycle.
  - in_ready = !s1_valid || s1_advance.
  - Latency: input handshake at edge N gives out_valid at edge N+2.
  - Sustains 1 transaction per cycle when out_ready=1.
  - With out_ready=0 the unit holds at most 2 transactions, then in_ready=0.
- Functions, all bitwise on WORD_W bits. ROTR is rotate right, SHR is logical shift right.
  - MAJ = (a&b)^(a&c)^(b&c).
  - CH = (a&b)^(~a&c).
  - For WORD_W=32:
    - BSIG0 = ROTR2^ROTR13^ROTR22.
    - BSIG1 = ROTR6^ROTR11^ROTR25.
    - SSIG0 = ROTR7^ROTR18^SHR3.
    - SSIG1 = ROTR17^ROTR19^SHR10.
  - For WORD_W=64:
    - BSIG0 = ROTR28^ROTR34^ROTR39.
    - BSIG1 = ROTR14^ROTR18^ROTR41.
    - SSIG0 = ROTR1^ROTR8^SHR7.
    - SSIG1 = ROTR19^ROTR61^SHR6.
  - No arithmetic and no carries; the result is exactly WORD_W bits.
- Illegal op (6 or 7): out_result=0, out_err=1. The transaction still flows and is counted. out_err=0 for legal ops.
- op_count increments on each output handshake and wraps from 2^CNT_W-1 to 0. It is not incremented on input.
- Simultaneous input and output handshakes in the same cycle with both stages full are legal. No bubble may be inserted and no data overwritten.

Decomposition:
- Shared package sha2_pkg holds:
  - the op-code enum (OP_MAJ..OP_SSIG1);
  - the rotate/shift constants for both widths, as localparams indexed by WORD_W;
  - a rotr function.
- Sub-module sha2_logic_comb: purely combinational, takes op, a, b, c and returns result and err. It is instantiated once between S1 and S2.
- The pipeline and handshake logic stay in the top module.

Test Plan:
- WORD_W=32, MAJ, a=6a09e667 b=bb67ae85 c=3c6ef372, out_ready=1 -> out_result=3a6fe667 exactly 2 cycles later, out_err=0, op_count=1.
- WORD_W=32, back-to-back:
  - CH e=510e527f f=9b05688c g=1f83d9ab -> 1f85c98c;
  - BSIG1 a=510e527f -> 3587272b;
  - BSIG0 a=6a09e667 -> ce20b47e;
  - SSIG0 a=00000001 -> 02004000;
  - results arrive on consecutive cycles with tags 1,2,3,4 in order.
- Backpressure: out_ready=0, drive 3 valid inputs -> in_ready drops after 2 are accepted. out_result stays stable. Releasing out_ready yields tags in order, with no loss or duplication.
- Illegal op 7 with tag 5 -> out_result=0, out_err=1, out_tag=5, op_count increments.
- WORD_W=64, MAJ a=FFFFFFFF00000000 b=FFFF0000FFFF0000 c=0 -> FFFF000000000000.
- Reset asserted with both stages full -> out_valid=0 and op_count=0 asynchronously. A fresh input after release gives the correct result with no stale output; CNT_W=2 wraps 3->0 after 4 handshakes.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 logical-function pipeline: op codes, sigma rotate/shift
// amounts for SHA-256 and SHA-512, and a width-aware rotate helper.
package sha2_pkg;

  typedef enum logic [2:0] {
    OP_MAJ   = 3'd0,
    OP_CH    = 3'd1,
    OP_BSIG0 = 3'd2,
    OP_BSIG1 = 3'd3,
    OP_SSIG0 = 3'd4,
    OP_SSIG1 = 3'd5
  } sha2_op_e;

  // Rows: BSIG0, BSIG1, SSIG0, SSIG1. The third entry of an SSIG row is a shift, not a rotate.
  localparam int unsigned SigAmt32 [4][3] = '{'{2, 13, 22}, '{6, 11, 25},
                                              '{7, 18, 3},  '{17, 19, 10}};
  localparam int unsigned SigAmt64 [4][3] = '{'{28, 34, 39}, '{14, 18, 41},
                                              '{1, 8, 7},    '{19, 61, 6}};

  function automatic int unsigned sig_amt(input int unsigned word_w, input logic [1:0] fn,
                                          input logic [1:0] k);
    return (word_w == 64) ? SigAmt64[fn][k] : SigAmt32[fn][k];
  endfunction

  // Rotate the low w bits of x right by n (0 < n < w); bits above w come back as zero.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

endpackage

// File: rtl/sha2_logic_comb.sv
// Combinational SHA-2 logical functions: Maj, Ch and the four sigma functions on one word.
// Illegal op codes return zero with the error flag set.
module sha2_logic_comb
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [2:0]        op_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [WORD_W-1:0] c_i,
  output logic [WORD_W-1:0] result_o,
  output logic              err_o
);

  function automatic logic [WORD_W-1:0] sigma(input logic [WORD_W-1:0] x, input logic [1:0] fn);
    logic [63:0] xw;
    logic [63:0] t;
    xw = 64'(x);
    t  = rotr(xw, sig_amt(WORD_W, fn, 2'd0), WORD_W) ^ rotr(xw, sig_amt(WORD_W, fn, 2'd1), WORD_W);
    if (fn[1]) t = t ^ (xw >> sig_amt(WORD_W, fn, 2'd2));
    else       t = t ^ rotr(xw, sig_amt(WORD_W, fn, 2'd2), WORD_W);
    return t[WORD_W-1:0];
  endfunction

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_MAJ:   result_o = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
      OP_CH:    result_o = (a_i & b_i) ^ (~a_i & c_i);
      OP_BSIG0: result_o = sigma(a_i, 2'd0);
      OP_BSIG1: result_o = sigma(a_i, 2'd1);
      OP_SSIG0: result_o = sigma(a_i, 2'd2);
      OP_SSIG1: result_o = sigma(a_i, 2'd3);
      default:  err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha2_logic_pipe.sv
// Two-stage elastic valid/ready pipeline around the SHA-2 logical-function unit, with a
// pass-through tag, illegal-op flag and a wrapping completed-operation counter.
module sha2_logic_pipe #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [WORD_W-1:0] in_c,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  op_count
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_logic_pipe: WORD_W must be 32 or 64");
  end

  logic              s1_valid_q, s2_valid_q;
  logic [2:0]        s1_op_q;
  logic [WORD_W-1:0] s1_a_q, s1_b_q, s1_c_q;
  logic [TAG_W-1:0]  s1_tag_q, s2_tag_q;
  logic [WORD_W-1:0] s2_result_q;
  logic              s2_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_hs, out_hs, s1_adv;
  logic              s1_valid_d, s2_valid_d;
  logic [WORD_W-1:0] res_d;
  logic              err_d;

  // in_ready looks only at stored state and out_ready, never at in_valid.
  always_comb begin
    out_hs     = s2_valid_q & out_ready;
    s1_adv     = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s1_adv;
    in_hs      = in_valid & in_ready;
    s1_valid_d = in_hs | (s1_valid_q & ~s1_adv);
    s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
  end

  sha2_logic_comb #(
    .WORD_W(WORD_W)
  ) u_comb (
    .op_i    (s1_op_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .c_i     (s1_c_q),
    .result_o(res_d),
    .err_o   (err_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
      s2_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_hs) begin
        s1_op_q  <= in_op;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_c_q   <= in_c;
        s1_tag_q <= in_tag;
      end
      if (s1_adv) begin
        s2_result_q <= res_d;
        s2_tag_q    <= s1_tag_q;
        s2_err_q    <= err_d;
      end
      if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign out_err    = s2_err_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_sha2_logic_pipe.sv
// Directed bench for sha2_logic_pipe: a 32-bit instance and a 64-bit instance with a 2-bit
// counter, checked against hand-computed SHA-2 function values.
module tb_sha2_logic_pipe;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, in_c, out_result;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] op_count;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_err64;
  logic [2:0]  in_op64;
  logic [63:0] in_a64, in_b64, in_c64, out_result64;
  logic [3:0]  in_tag64, out_tag64;
  logic [1:0]  op_count64;

  int n_vec  = 0;
  int n_miss = 0;

  sha2_logic_pipe #(.WORD_W(32), .TAG_W(4), .CNT_W(16)) u_dut32 (
    .clock     (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  sha2_logic_pipe #(.WORD_W(64), .TAG_W(4), .CNT_W(2)) u_dut64 (
    .clock     (clk),
    .reset     (rst_n),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .in_op     (in_op64),
    .in_a      (in_a64),
    .in_b      (in_b64),
    .in_c      (in_c64),
    .in_tag    (in_tag64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .out_result(out_result64),
    .out_tag   (out_tag64),
    .out_err   (out_err64),
    .op_count  (op_count64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_tag   = tag;
  endtask

  // Back-to-back vectors for the 32-bit instance
  logic [2:0]  b2b_op  [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
  logic [31:0] b2b_a   [4] = '{32'h510e527f, 32'h510e527f, 32'h6a09e667, 32'h00000001};
  logic [31:0] b2b_b   [4] = '{32'h9b05688c, 32'h0, 32'h0, 32'h0};
  logic [31:0] b2b_c   [4] = '{32'h1f83d9ab, 32'h0, 32'h0, 32'h0};
  logic [31:0] b2b_exp [4] = '{32'h1f85c98c, 32'h3587272b, 32'hce20b47e, 32'h02004000};

  // 64-bit vectors; the fourth is illegal op 6
  logic [2:0]  w_op  [4] = '{3'd0, 3'd2, 3'd5, 3'd6};
  logic [63:0] w_a   [4] = '{64'hFFFFFFFF00000000, 64'h1, 64'h1, 64'hFFFFFFFFFFFFFFFF};
  logic [63:0] w_b   [4] = '{64'hFFFF0000FFFF0000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF};
  logic [63:0] w_exp [4] = '{64'hFFFF000000000000, 64'h0000001042000000,
                             64'h0000200000000008, 64'h0};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
    out_ready = 1'b1;
    in_valid64 = 1'b0; in_op64 = '0; in_a64 = '0; in_b64 = '0; in_c64 = '0; in_tag64 = '0;
    out_ready64 = 1'b1;
    #3;
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_op_count", 64'(op_count), 64'd0);
    check_eq("reset_out_result", 64'(out_result), 64'd0);
    #9 rst_n = 1'b1;
    step();
    check_eq("ready_after_reset", 64'(in_ready), 64'd1);

    // Single MAJ, latency check
    drive32(3'd0, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 4'd0);
    step();
    in_valid = 1'b0;
    check_eq("maj_not_early", 64'(out_valid), 64'd0);
    step();
    check_eq("maj_valid", 64'(out_valid), 64'd1);
    check_eq("maj_result", 64'(out_result), 64'h3a6fe667);
    check_eq("maj_err", 64'(out_err), 64'd0);
    step();
    check_eq("maj_count", 64'(op_count), 64'd1);
    check_eq("maj_drained", 64'(out_valid), 64'd0);

    // Back-to-back, tags 1..4
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive32(b2b_op[k], b2b_a[k], b2b_b[k], b2b_c[k], 4'(k + 1));
      else in_valid = 1'b0;
      step();
      if (k >= 1) begin
        check_eq($sformatf("b2b_valid%0d", k), 64'(out_valid), 64'd1);
        check_eq($sformatf("b2b_tag%0d", k), 64'(out_tag), 64'(k));
        check_eq($sformatf("b2b_result%0d", k), 64'(out_result), 64'(b2b_exp[k-1]));
      end
    end
    step();
    check_eq("b2b_count", 64'(op_count), 64'd5);

    // Backpressure: CH with a=all-ones passes b through
    out_ready = 1'b0;
    drive32(3'd1, 32'hffffffff, 32'h108, 32'h0, 4'd8);
    check_eq("bp_ready0", 64'(in_ready), 64'd1);
    step();
    check_eq("bp_ready1", 64'(in_ready), 64'd1);
    drive32(3'd1, 32'hffffffff, 32'h109, 32'h0, 4'd9);
    step();
    check_eq("bp_full_ready", 64'(in_ready), 64'd0);
    check_eq("bp_tag8", 64'(out_tag), 64'd8);
    check_eq("bp_res8", 64'(out_result), 64'h108);
    drive32(3'd1, 32'hffffffff, 32'h10a, 32'h0, 4'd10);
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
      check_eq("bp_hold_tag", 64'(out_tag), 64'd8);
      check_eq("bp_hold_res", 64'(out_result), 64'h108);
      check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_tag9", 64'(out_tag), 64'd9);
    check_eq("bp_res9", 64'(out_result), 64'h109);
    step();
    check_eq("bp_tag10", 64'(out_tag), 64'd10);
    check_eq("bp_res10", 64'(out_result), 64'h10a);
    step();
    check_eq("bp_drained", 64'(out_valid), 64'd0);
    check_eq("bp_count", 64'(op_count), 64'd8);

    // Illegal op 7
    drive32(3'd7, 32'hffffffff, 32'hffffffff, 32'hffffffff, 4'd5);
    step();
    in_valid = 1'b0;
    step();
    check_eq("ill_valid", 64'(out_valid), 64'd1);
    check_eq("ill_result", 64'(out_result), 64'd0);
    check_eq("ill_err", 64'(out_err), 64'd1);
    check_eq("ill_tag", 64'(out_tag), 64'd5);
    step();
    check_eq("ill_count", 64'(op_count), 64'd9);

    // 64-bit instance, 2-bit counter wraps after 4 handshakes
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        in_valid64 = 1'b1;
        in_op64    = w_op[k];
        in_a64     = w_a[k];
        in_b64     = w_b[k];
        in_c64     = '0;
        in_tag64   = 4'(k + 1);
      end else begin
        in_valid64 = 1'b0;
      end
      step();
      if (k >= 1) begin
        check_eq($sformatf("w64_valid%0d", k), 64'(out_valid64), 64'd1);
        check_eq($sformatf("w64_tag%0d", k), 64'(out_tag64), 64'(k));
        check_eq($sformatf("w64_result%0d", k), out_result64, w_exp[k-1]);
        check_eq($sformatf("w64_err%0d", k), 64'(out_err64), 64'(k == 4));
        check_eq($sformatf("w64_count%0d", k), 64'(op_count64), 64'(k - 1));
      end
    end
    step();
    check_eq("w64_wrap", 64'(op_count64), 64'd0);
    check_eq("w64_drained", 64'(out_valid64), 64'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive32(3'd0, 32'hffffffff, 32'hffffffff, 32'h0, 4'd11);
    step();
    drive32(3'd1, 32'hffffffff, 32'h55, 32'h0, 4'd12);
    step();
    in_valid = 1'b0;
    check_eq("rst_full_valid", 64'(out_valid), 64'd1);
    check_eq("rst_full_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_count", 64'(op_count), 64'd0);
    check_eq("async_rst_tag", 64'(out_tag), 64'd0);
    #2 rst_n = 1'b1;
    step();
    check_eq("post_rst_no_stale", 64'(out_valid), 64'd0);
    check_eq("post_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive32(3'd4, 32'h00000001, 32'h0, 32'h0, 4'd3);
    step();
    in_valid = 1'b0;
    check_eq("post_rst_not_early", 64'(out_valid), 64'd0);
    step();
    check_eq("post_rst_valid", 64'(out_valid), 64'd1);
    check_eq("post_rst_result", 64'(out_result), 64'h02004000);
    check_eq("post_rst_tag", 64'(out_tag), 64'd3);
    step();
    check_eq("post_rst_count", 64'(op_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
